// File: rtl/gen_async_fifo_rd_ctrl_pkg.sv
// Shared constants for the async FIFO read-side controller.
package gen_async_fifo_rd_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_AE_THRESH  = 2;
   localparam int PTR_WIDTH      = DEF_ADDR_WIDTH + 1;

endpackage

// File: rtl/gen_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above it.
module gen_gray2bin #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic [ADDR_WIDTH:0] gray,
   output logic [ADDR_WIDTH:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gen_async_fifo_rd_ctrl.sv
// Read-domain controller for an async FIFO: write-pointer synchronizer, read
// pointers and empty flag. GEN_FIFO_RD_LEVEL_EN adds rd_level/almost_empty.
module gen_async_fifo_rd_ctrl
   import gen_async_fifo_rd_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AE_THRESH  = DEF_AE_THRESH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH:0]   wr_gptr_async,
   input  logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   rd_gptr,
   output logic                  empty,
`ifdef GEN_FIFO_RD_LEVEL_EN
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  almost_empty,
`endif
   output logic                  rd_underflow
);

   logic [ADDR_WIDTH:0] sync1;
   logic [ADDR_WIDTH:0] sync2;
   logic [ADDR_WIDTH:0] rd_bin;
   logic [ADDR_WIDTH:0] rd_bin_next;
   logic [ADDR_WIDTH:0] rd_gray_next;
   logic                rd_ok;

   assign rd_ok        = rd_en && !empty;
   assign rd_bin_next  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_ok};
   assign rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next;
   assign rd_addr      = rd_bin[ADDR_WIDTH-1:0];

   // Plain two-flop chain; nothing may sit between the stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= wr_gptr_async;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_bin       <= '0;
         rd_gptr      <= '0;
         empty        <= 1'b1;
         rd_underflow <= 1'b0;
      end else begin
         rd_bin       <= rd_bin_next;
         rd_gptr      <= rd_gray_next;
         empty        <= (rd_gray_next == sync2);
         rd_underflow <= rd_en && empty;
      end
   end

`ifdef GEN_FIFO_RD_LEVEL_EN
   localparam logic [ADDR_WIDTH:0] AE_LIMIT = AE_THRESH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH:0] wr_bin_sync;
   logic [ADDR_WIDTH:0] level_next;

   gen_gray2bin #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_gray2bin (
      .gray (sync2),
      .bin  (wr_bin_sync)
   );

   // Modulo subtraction handles the wrap of either pointer.
   assign level_next = wr_bin_sync - rd_bin_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_level     <= '0;
         almost_empty <= 1'b1;
      end else begin
         rd_level     <= level_next;
         almost_empty <= (level_next <= AE_LIMIT);
      end
   end
`endif

endmodule

// File: tb/tb_gen_async_fifo_rd_ctrl.sv
// Directed bench for gen_async_fifo_rd_ctrl (ADDR_WIDTH=4, AE_THRESH=2):
// vector table plus wrap, reset-mid-operation and level sequences.
module tb_gen_async_fifo_rd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] wr_gptr_async;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [4:0] rd_gptr;
   logic       empty;
   logic       rd_underflow;
`ifdef GEN_FIFO_RD_LEVEL_EN
   logic [4:0] rd_level;
   logic       almost_empty;
`endif

   int total = 0;
   int bad   = 0;

   gen_async_fifo_rd_ctrl #(
      .ADDR_WIDTH (4),
      .AE_THRESH  (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_gptr_async (wr_gptr_async),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_gptr       (rd_gptr),
      .empty         (empty),
`ifdef GEN_FIFO_RD_LEVEL_EN
      .rd_level      (rd_level),
      .almost_empty  (almost_empty),
`endif
      .rd_underflow  (rd_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [4:0] wg;
      logic       rd;
      logic       e_empty;
      logic [4:0] e_gptr;
      logic [3:0] e_addr;
      logic       e_uf;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic rst, logic [4:0] wg, logic rd, logic e_empty,
                               logic [4:0] e_gptr, logic [3:0] e_addr, logic e_uf);
      vec_t v;
      v.rst = rst; v.wg = wg; v.rd = rd; v.e_empty = e_empty;
      v.e_gptr = e_gptr; v.e_addr = e_addr; v.e_uf = e_uf;
      return v;
   endfunction

   function automatic logic [4:0] gray5(int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_not_empty(string name, int budget);
      int n;
      n = 0;
      while (empty === 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(name, {31'd0, empty}, 32'd0);
   endtask

   initial begin
      logic [4:0] prev_gptr;

      reset = 1'b1;
      wr_gptr_async = '0;
      rd_en = 1'b0;

      vecs[0]  = mk(1, 5'd0, 0, 1, 5'b00000, 4'd0, 0);
      vecs[1]  = mk(1, 5'd0, 1, 1, 5'b00000, 4'd0, 0);
      vecs[2]  = mk(0, 5'd0, 1, 1, 5'b00000, 4'd0, 1);
      vecs[3]  = mk(0, 5'd0, 0, 1, 5'b00000, 4'd0, 0);
      vecs[4]  = mk(0, 5'b00001, 0, 1, 5'b00000, 4'd0, 0);
      vecs[5]  = mk(0, 5'b00001, 0, 1, 5'b00000, 4'd0, 0);
      vecs[6]  = mk(0, 5'b00001, 0, 0, 5'b00000, 4'd0, 0);
      vecs[7]  = mk(0, 5'b00001, 1, 1, 5'b00001, 4'd1, 0);
      vecs[8]  = mk(0, 5'b00001, 1, 1, 5'b00001, 4'd1, 1);
      vecs[9]  = mk(0, 5'b00010, 0, 1, 5'b00001, 4'd1, 0);
      vecs[10] = mk(0, 5'b00010, 0, 1, 5'b00001, 4'd1, 0);
      vecs[11] = mk(0, 5'b00010, 1, 0, 5'b00001, 4'd1, 1);
      vecs[12] = mk(0, 5'b00010, 1, 0, 5'b00011, 4'd2, 0);
      vecs[13] = mk(0, 5'b00010, 1, 1, 5'b00010, 4'd3, 0);
      vecs[14] = mk(1, 5'b00010, 1, 1, 5'b00000, 4'd0, 0);
      vecs[15] = mk(0, 5'b00010, 0, 1, 5'b00000, 4'd0, 0);
      vecs[16] = mk(0, 5'b00010, 0, 1, 5'b00000, 4'd0, 0);
      vecs[17] = mk(0, 5'b00010, 0, 0, 5'b00000, 4'd0, 0);
      vecs[18] = mk(0, 5'b00010, 1, 0, 5'b00001, 4'd1, 0);
      vecs[19] = mk(0, 5'b00010, 1, 0, 5'b00011, 4'd2, 0);
      vecs[20] = mk(0, 5'b00010, 1, 1, 5'b00010, 4'd3, 0);
      vecs[21] = mk(0, 5'b00010, 1, 1, 5'b00010, 4'd3, 1);

      @(negedge clk);
      for (int i = 0; i < 22; i++) begin
         reset = vecs[i].rst;
         wr_gptr_async = vecs[i].wg;
         rd_en = vecs[i].rd;
         step();
         check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].e_empty});
         check($sformatf("vec%0d_gptr", i), {27'd0, rd_gptr}, {27'd0, vecs[i].e_gptr});
         check($sformatf("vec%0d_addr", i), {28'd0, rd_addr}, {28'd0, vecs[i].e_addr});
         check($sformatf("vec%0d_uf", i), {31'd0, rd_underflow}, {31'd0, vecs[i].e_uf});
`ifdef GEN_FIFO_RD_LEVEL_EN
         if (i == 1) begin
            check("reset_level", {27'd0, rd_level}, 32'd0);
            check("reset_ae", {31'd0, almost_empty}, 32'd1);
         end
`endif
      end

      // Wrap: one entry at a time through a full 32-step pointer cycle.
      reset = 1'b1; rd_en = 1'b0; wr_gptr_async = '0;
      step(); step();
      reset = 1'b0;
      prev_gptr = rd_gptr;
      for (int i = 1; i <= 32; i++) begin
         wr_gptr_async = gray5(i);
         wait_not_empty($sformatf("wrap%0d_fill", i), 8);
         rd_en = 1'b1;
         step();
         rd_en = 1'b0;
         check($sformatf("wrap%0d_gptr", i), {27'd0, rd_gptr}, {27'd0, gray5(i)});
         check($sformatf("wrap%0d_onebit", i), $countones(rd_gptr ^ prev_gptr), 32'd1);
         check($sformatf("wrap%0d_empty", i), {31'd0, empty}, 32'd1);
         prev_gptr = rd_gptr;
      end
      check("wrap_addr_end", {28'd0, rd_addr}, 32'd0);

      // Reset with rd_bin=7 and a read pending.
      wr_gptr_async = gray5(7);
      step(); step(); step();
      rd_en = 1'b1;
      for (int i = 0; i < 7; i++) step();
      check("pre_rst_gptr", {27'd0, rd_gptr}, {27'd0, gray5(7)});
      check("pre_rst_addr", {28'd0, rd_addr}, 32'd7);
      check("pre_rst_empty", {31'd0, empty}, 32'd1);
      reset = 1'b1;
      wr_gptr_async = '0;
      step();
      check("mid_rst_gptr", {27'd0, rd_gptr}, 32'd0);
      check("mid_rst_addr", {28'd0, rd_addr}, 32'd0);
      check("mid_rst_empty", {31'd0, empty}, 32'd1);
      check("mid_rst_uf", {31'd0, rd_underflow}, 32'd0);
      reset = 1'b0;
      rd_en = 1'b0;
      step();
      check("post_rst_uf", {31'd0, rd_underflow}, 32'd0);
      wr_gptr_async = 5'b00001;
      step(); step();
      check("post_rst_still_empty", {31'd0, empty}, 32'd1);
      step();
      check("post_rst_not_empty", {31'd0, empty}, 32'd0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("post_rst_gptr", {27'd0, rd_gptr}, 32'd1);
      check("post_rst_addr", {28'd0, rd_addr}, 32'd1);
      check("post_rst_empty", {31'd0, empty}, 32'd1);

`ifdef GEN_FIFO_RD_LEVEL_EN
      reset = 1'b1; wr_gptr_async = '0;
      step();
      reset = 1'b0;
      wr_gptr_async = 5'b00111;
      step(); step(); step();
      check("level5", {27'd0, rd_level}, 32'd5);
      check("level5_ae", {31'd0, almost_empty}, 32'd0);
      rd_en = 1'b1;
      step(); step(); step();
      rd_en = 1'b0;
      check("level2", {27'd0, rd_level}, 32'd2);
      check("level2_ae", {31'd0, almost_empty}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
